// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO sweep controller and its dwell counter.
package nco_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Step width equals the full NCO phase accumulator width.
   function automatic int accSize(input int lutLength, input int fracBits);
      return lutLength + fracBits;
   endfunction

endpackage

// File: rtl/nco_dwell_counter.sv
// Down-counter that marks the last cycle of each dwell period and reloads itself on terminal count.
module nco_dwell_counter #(
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   iclk,
   input  logic                   ireset,
   input  logic                   iload,
   input  logic                   ien,
   input  logic [DWELL_WIDTH-1:0] idwell,
   output logic                   otc
);

   logic [DWELL_WIDTH-1:0] r_reload;
   logic [DWELL_WIDTH-1:0] r_count;
   logic [DWELL_WIDTH-1:0] w_loadValue;

   // A dwell of zero behaves exactly like a dwell of one.
   assign w_loadValue = (idwell == '0) ? DWELL_WIDTH'(1) : idwell;
   assign otc         = ien && (r_count == DWELL_WIDTH'(1));

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         r_reload <= DWELL_WIDTH'(1);
         r_count  <= DWELL_WIDTH'(1);
      end else if (iload) begin
         r_reload <= w_loadValue;
         r_count  <= w_loadValue;
      end else if (ien) begin
         if (otc) begin
            r_count <= r_reload;
         end else begin
            r_count <= r_count - DWELL_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/nco_sweep_controller.sv
// Frequency sweep / chirp sequencer driving the step and chip-select inputs of lut_based_nco.
// Walks the step from first to last in delta increments, holding each value for a dwell period.
module nco_sweep_controller
   import nco_ctrl_pkg::*;
#(
   parameter  int LUT_LENGTH                = 6,
   parameter  int PHASE_BITWIDTH_FRACTIONAL = 3,
   parameter  int DWELL_WIDTH               = 16,
   localparam int ACC_SIZE                  = accSize(LUT_LENGTH, PHASE_BITWIDTH_FRACTIONAL)
) (
   input  logic                   iclk,
   input  logic                   ireset,
   input  logic                   istart,
   input  logic                   iabort,
   input  logic                   imode,
   input  logic [ACC_SIZE-1:0]    istep_first,
   input  logic [ACC_SIZE-1:0]    istep_last,
   input  logic [ACC_SIZE-1:0]    istep_delta,
   input  logic [DWELL_WIDTH-1:0] idwell,
   output logic [ACC_SIZE-1:0]    ostep,
   output logic                   onCS,
   output logic                   obusy,
   output logic                   odone
);

   state_t r_state, w_nextState;
   logic   r_primed, w_nextPrimed;

   logic [ACC_SIZE-1:0] r_first;
   logic [ACC_SIZE-1:0] r_last;
   logic [ACC_SIZE-1:0] r_delta;
   logic                r_mode;
   dir_t                r_dir;

   logic [ACC_SIZE-1:0] r_step, w_nextStep;
   logic                r_ncs, w_nextNcs;
   logic                r_busy, w_nextBusy;
   logic                r_done, w_nextDone;

   logic w_accept;
   logic w_tc;
   logic w_atEnd;

   logic signed [ACC_SIZE:0] w_stepExt;
   logic signed [ACC_SIZE:0] w_lastExt;
   logic signed [ACC_SIZE:0] w_deltaExt;
   logic signed [ACC_SIZE:0] w_sum;
   logic        [ACC_SIZE-1:0] w_nextValue;

   assign w_accept = (r_state == IDLE) && istart && !iabort;

   nco_dwell_counter #(
      .DWELL_WIDTH(DWELL_WIDTH)
   ) u_dwell (
      .iclk   (iclk),
      .ireset (ireset),
      .iload  (w_accept),
      .ien    ((r_state == RUN) && !r_primed),
      .idwell (idwell),
      .otc    (w_tc)
   );

   // One extra bit of headroom lets an overshoot be detected and clamped instead of wrapping.
   assign w_stepExt  = {r_step[ACC_SIZE-1], r_step};
   assign w_lastExt  = {r_last[ACC_SIZE-1], r_last};
   assign w_deltaExt = {1'b0, r_delta};
   assign w_sum      = (r_dir == DIR_UP) ? (w_stepExt + w_deltaExt) : (w_stepExt - w_deltaExt);

   always_comb begin
      w_nextValue = w_sum[ACC_SIZE-1:0];
      if ((r_dir == DIR_UP) && (w_sum > w_lastExt)) begin
         w_nextValue = r_last;
      end else if ((r_dir == DIR_DOWN) && (w_sum < w_lastExt)) begin
         w_nextValue = r_last;
      end
   end

   assign w_atEnd = (r_step == r_last) || (r_delta == '0);

   // The cycle after acceptance is a priming cycle; the first step appears one edge later.
   always_comb begin
      w_nextState  = r_state;
      w_nextPrimed = r_primed;
      w_nextStep   = r_step;
      w_nextNcs    = r_ncs;
      w_nextBusy   = r_busy;
      w_nextDone   = 1'b0;
      case (r_state)
         IDLE: begin
            w_nextStep = '0;
            w_nextNcs  = 1'b1;
            w_nextBusy = 1'b0;
            if (w_accept) begin
               w_nextState  = RUN;
               w_nextPrimed = 1'b1;
            end
         end
         RUN: begin
            if (iabort) begin
               w_nextState  = IDLE;
               w_nextPrimed = 1'b0;
               w_nextStep   = '0;
               w_nextNcs    = 1'b1;
               w_nextBusy   = 1'b0;
            end else if (r_primed) begin
               w_nextPrimed = 1'b0;
               w_nextStep   = r_first;
               w_nextNcs    = 1'b0;
               w_nextBusy   = 1'b1;
            end else if (w_tc) begin
               if (!w_atEnd) begin
                  w_nextStep = w_nextValue;
               end else if (r_mode) begin
                  w_nextStep = r_first;
               end else begin
                  w_nextState = DONE;
                  w_nextDone  = 1'b1;
                  w_nextStep  = '0;
                  w_nextNcs   = 1'b1;
                  w_nextBusy  = 1'b0;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
            w_nextStep  = '0;
            w_nextNcs   = 1'b1;
            w_nextBusy  = 1'b0;
         end
         default: begin
            w_nextState  = IDLE;
            w_nextPrimed = 1'b0;
            w_nextStep   = '0;
            w_nextNcs    = 1'b1;
            w_nextBusy   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         r_state  <= IDLE;
         r_primed <= 1'b0;
         r_step   <= '0;
         r_ncs    <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_primed <= w_nextPrimed;
         r_step   <= w_nextStep;
         r_ncs    <= w_nextNcs;
         r_busy   <= w_nextBusy;
         r_done   <= w_nextDone;
      end
   end

   // Shadow copies freeze the sweep parameters for the whole run.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         r_first <= '0;
         r_last  <= '0;
         r_delta <= '0;
         r_mode  <= 1'b0;
         r_dir   <= DIR_UP;
      end else if (w_accept) begin
         r_first <= istep_first;
         r_last  <= istep_last;
         r_delta <= istep_delta;
         r_mode  <= imode;
         r_dir   <= ($signed(istep_last) >= $signed(istep_first)) ? DIR_UP : DIR_DOWN;
      end
   end

   assign ostep = r_step;
   assign onCS  = r_ncs;
   assign obusy = r_busy;
   assign odone = r_done;

endmodule
